// File: rtl/isa_pkg.sv
// isa_pkg: shared definitions for the fetch sequencer slice.
//   - state_e      : sequencer state encoding (RUN / HALT / ERR), 2 bits
//   - CNT_MAX_DEF  : default highest legal instruction step
//   - RESET_PC_DEF : default PC loaded on reset
//   - INSM_* / INSL_* : IR bit positions of the decoder opcode fields
package isa_pkg;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HALT = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  localparam logic [2:0]  CNT_MAX_DEF  = 3'd7;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

  localparam int INSM_HI = 15;
  localparam int INSM_LO = 8;
  localparam int INSL_HI = 1;
  localparam int INSL_LO = 0;

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: bundle between instruction memory / PC-next mux /
// decoder and the fetch sequencer.
//   Into the sequencer : MEM_rdata, PC_next, Buff_PC, Done
//   Out of the sequencer: MEM_addr, PC, IR, InsM, InsL, Cnt, Halted,
//                         Seq_Err, Retired
//   modport slave  : the sequencer side
//   modport master : the surrounding core (or a testbench)
interface fetch_sequencer_if #(
  parameter int AW = 16,
  parameter int DW = 16
);

  logic [DW-1:0] MEM_rdata;
  logic [AW-1:0] PC_next;
  logic          Buff_PC;
  logic          Done;
  logic [AW-1:0] MEM_addr;
  logic [AW-1:0] PC;
  logic [DW-1:0] IR;
  logic [7:0]    InsM;
  logic [1:0]    InsL;
  logic [2:0]    Cnt;
  logic          Halted;
  logic          Seq_Err;
  logic [15:0]   Retired;

  modport slave (
    input  MEM_rdata, PC_next, Buff_PC, Done,
    output MEM_addr, PC, IR, InsM, InsL, Cnt, Halted, Seq_Err, Retired
  );

  modport master (
    output MEM_rdata, PC_next, Buff_PC, Done,
    input  MEM_addr, PC, IR, InsM, InsL, Cnt, Halted, Seq_Err, Retired
  );

endinterface

// File: rtl/step_counter.sv
// step_counter: instruction step counter.
//   clk      : clock
//   i_rst    : synchronous active-high reset, counter to 0
//   i_clr    : clear counter to 0 (instruction end / halt)
//   i_en     : advance by one; holds once CNT_MAX is reached
//   o_cnt    : current step
//   o_at_max : o_cnt equals CNT_MAX
module step_counter #(
  parameter int             CW      = 3,
  parameter logic [CW-1:0]  CNT_MAX = '1
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt,
  output logic          o_at_max
);

  logic [CW-1:0] r_cnt;

  assign o_cnt    = r_cnt;
  assign o_at_max = (r_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_at_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: holds PC, fetches the instruction word into IR and runs
// the step counter that the decoder uses to sequence each instruction.
//   clk  : clock, all state changes on the rising edge
//   Rst  : synchronous active-high reset, dominates every other input
//   bus  : fetch_sequencer_if.slave
//          in : MEM_rdata (word at MEM_addr), PC_next, Buff_PC, Done
//          out: MEM_addr(=PC), PC, IR, InsM, InsL, Cnt, Halted, Seq_Err,
//               Retired
// Step 0 latches the fetched word; steps 1..CNT_MAX wait for Buff_PC
// (commit PC_next) or Done (halt). Running off the end of the step range
// is a sequencing error. HALT and ERR are absorbing until reset.
module fetch_sequencer
  import isa_pkg::*;
#(
  parameter int            AW       = 16,
  parameter int            DW       = 16,
  parameter logic [AW-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [2:0]    CNT_MAX  = CNT_MAX_DEF
) (
  input logic              clk,
  input logic              Rst,
  fetch_sequencer_if.slave bus
);

  state_e        r_state;
  logic [AW-1:0] r_pc;
  logic [DW-1:0] r_ir;
  logic          r_halted;
  logic          r_seq_err;
  logic [15:0]   r_retired;

  logic [2:0]    w_cnt;
  logic          w_at_max;
  logic          w_run;
  logic          w_cnt_zero;
  logic          w_cnt_clr;
  logic          w_cnt_en;

  assign w_run      = (r_state == S_RUN);
  assign w_cnt_zero = (w_cnt == 3'd0);

  // Buff_PC or Done end the instruction only once it has been fetched;
  // at step 0 both are ignored for sequencing and the fetch always runs.
  assign w_cnt_clr = w_run && !w_cnt_zero && (bus.Buff_PC || bus.Done);
  // The counter freezes outside RUN; it saturates on its own at CNT_MAX.
  assign w_cnt_en  = w_run && !w_cnt_clr;

  step_counter #(
    .CW      (3),
    .CNT_MAX (CNT_MAX)
  ) u_step_counter (
    .clk      (clk),
    .i_rst    (Rst),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .o_cnt    (w_cnt),
    .o_at_max (w_at_max)
  );

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_state   <= S_RUN;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_halted  <= 1'b0;
      r_seq_err <= 1'b0;
      r_retired <= 16'd0;
    end else if (w_run) begin
      if (w_cnt_zero) begin
        r_ir <= bus.MEM_rdata;
        // A commit before the instruction was even fetched is a decoder bug.
        if (bus.Buff_PC) begin
          r_seq_err <= 1'b1;
        end
      end else begin
        // Commit happens even alongside Done so PC ends up past the HLT.
        if (bus.Buff_PC) begin
          r_pc      <= bus.PC_next;
          r_retired <= r_retired + 16'd1;
        end
        if (bus.Done) begin
          r_state  <= S_HALT;
          r_halted <= 1'b1;
        end else if (!bus.Buff_PC && w_at_max) begin
          r_state   <= S_ERR;
          r_seq_err <= 1'b1;
        end
      end
    end
  end

  assign bus.MEM_addr = r_pc;
  assign bus.PC       = r_pc;
  assign bus.IR       = r_ir;
  assign bus.InsM     = r_ir[INSM_HI:INSM_LO];
  assign bus.InsL     = r_ir[INSL_HI:INSL_LO];
  assign bus.Cnt      = w_cnt;
  assign bus.Halted   = r_halted;
  assign bus.Seq_Err  = r_seq_err;
  assign bus.Retired  = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic Rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  fetch_sequencer_if #(.AW(16), .DW(16)) bus ();

  fetch_sequencer dut (
    .clk (clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory model: address 0 holds 16'h0800, every other
  // address a holds {a[7:0]+8'h20, a[7:0]}.
  function automatic logic [15:0] memf(input logic [15:0] a);
    if (a == 16'h0000) return 16'h0800;
    return {a[7:0] + 8'h20, a[7:0]};
  endfunction

  assign bus.MEM_rdata = memf(bus.MEM_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1; bus.Buff_PC = 1'b0; bus.Done = 1'b0; bus.PC_next = 16'h0000;
    step(); step();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    if (bus.PC !== 16'h0000) begin $display("FAIL reset_pc: got %h want %h", bus.PC, 16'h0000); miscompares++; end vectors++;
    if (bus.MEM_addr !== 16'h0000) begin $display("FAIL reset_addr: got %h want %h", bus.MEM_addr, 16'h0000); miscompares++; end vectors++;
    if (bus.IR !== 16'h0000) begin $display("FAIL reset_ir: got %h want %h", bus.IR, 16'h0000); miscompares++; end vectors++;
    if (bus.Cnt !== 3'd0) begin $display("FAIL reset_cnt: got %0d want 0", bus.Cnt); miscompares++; end vectors++;
    if (bus.Halted !== 1'b0) begin $display("FAIL reset_halted: got %b want 0", bus.Halted); miscompares++; end vectors++;
    if (bus.Seq_Err !== 1'b0) begin $display("FAIL reset_seqerr: got %b want 0", bus.Seq_Err); miscompares++; end vectors++;
    if (bus.Retired !== 16'd0) begin $display("FAIL reset_retired: got %0d want 0", bus.Retired); miscompares++; end vectors++;
    step();
    if (bus.IR !== 16'h0800) begin $display("FAIL first_fetch_ir: got %h want %h", bus.IR, 16'h0800); miscompares++; end vectors++;
    if (bus.InsM !== 8'h08) begin $display("FAIL first_fetch_insm: got %h want %h", bus.InsM, 8'h08); miscompares++; end vectors++;
    if (bus.Cnt !== 3'd1) begin $display("FAIL first_fetch_cnt: got %0d want 1", bus.Cnt); miscompares++; end vectors++;
  endtask

  task automatic test_normal();
    step(); step();
    if (bus.Cnt !== 3'd3) begin $display("FAIL normal_cnt3: got %0d want 3", bus.Cnt); miscompares++; end vectors++;
    bus.Buff_PC = 1'b1; bus.PC_next = 16'h0001;
    step();
    bus.Buff_PC = 1'b0;
    if (bus.PC !== 16'h0001) begin $display("FAIL normal_pc: got %h want %h", bus.PC, 16'h0001); miscompares++; end vectors++;
    if (bus.Cnt !== 3'd0) begin $display("FAIL normal_cnt0: got %0d want 0", bus.Cnt); miscompares++; end vectors++;
    if (bus.Retired !== 16'd1) begin $display("FAIL normal_retired: got %0d want 1", bus.Retired); miscompares++; end vectors++;
    if (bus.IR !== 16'h0800) begin $display("FAIL normal_ir_held: got %h want %h", bus.IR, 16'h0800); miscompares++; end vectors++;
    step();
    if (bus.IR !== 16'h2101) begin $display("FAIL normal_fetch_ir: got %h want %h", bus.IR, 16'h2101); miscompares++; end vectors++;
    if (bus.InsM !== 8'h21 || bus.InsL !== 2'b01) begin $display("FAIL normal_fields: got %h/%b want 21/01", bus.InsM, bus.InsL); miscompares++; end vectors++;
    if (bus.Cnt !== 3'd1) begin $display("FAIL normal_fetch_cnt: got %0d want 1", bus.Cnt); miscompares++; end vectors++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_pc [5] = '{16'h0001, 16'h0002, 16'h0040, 16'h0041, 16'h0042};
    do_reset();
    step();
    for (int k = 0; k < 5; k++) begin
      bus.Buff_PC = 1'b1;
      bus.PC_next = (k == 2) ? 16'h0040 : bus.PC + 16'h0001;
      step();
      bus.Buff_PC = 1'b0;
      if (bus.PC !== exp_pc[k]) begin $display("FAIL b2b_pc[%0d]: got %h want %h", k, bus.PC, exp_pc[k]); miscompares++; end vectors++;
      if (bus.Cnt !== 3'd0) begin $display("FAIL b2b_cnt0[%0d]: got %0d want 0", k, bus.Cnt); miscompares++; end vectors++;
      step();
      if (bus.Cnt !== 3'd1) begin $display("FAIL b2b_cnt1[%0d]: got %0d want 1", k, bus.Cnt); miscompares++; end vectors++;
      if (bus.IR !== memf(exp_pc[k])) begin $display("FAIL b2b_ir[%0d]: got %h want %h", k, bus.IR, memf(exp_pc[k])); miscompares++; end vectors++;
    end
    if (bus.Retired !== 16'd5) begin $display("FAIL b2b_retired: got %0d want 5", bus.Retired); miscompares++; end vectors++;
  endtask

  task automatic test_halt();
    step();
    bus.Done = 1'b1; bus.Buff_PC = 1'b1; bus.PC_next = 16'h0010;
    step();
    if (bus.PC !== 16'h0010) begin $display("FAIL halt_pc: got %h want %h", bus.PC, 16'h0010); miscompares++; end vectors++;
    if (bus.Halted !== 1'b1) begin $display("FAIL halt_halted: got %b want 1", bus.Halted); miscompares++; end vectors++;
    if (bus.Cnt !== 3'd0) begin $display("FAIL halt_cnt: got %0d want 0", bus.Cnt); miscompares++; end vectors++;
    if (bus.Retired !== 16'd6) begin $display("FAIL halt_retired: got %0d want 6", bus.Retired); miscompares++; end vectors++;
    bus.Done = 1'b0; bus.PC_next = 16'h0077;
    step(); step(); step();
    bus.Buff_PC = 1'b0;
    if (bus.PC !== 16'h0010) begin $display("FAIL halt_pc_frozen: got %h want %h", bus.PC, 16'h0010); miscompares++; end vectors++;
    if (bus.Cnt !== 3'd0) begin $display("FAIL halt_cnt_frozen: got %0d want 0", bus.Cnt); miscompares++; end vectors++;
    if (bus.Retired !== 16'd6) begin $display("FAIL halt_retired_frozen: got %0d want 6", bus.Retired); miscompares++; end vectors++;
    if (bus.IR !== 16'h6242) begin $display("FAIL halt_ir_frozen: got %h want %h", bus.IR, 16'h6242); miscompares++; end vectors++;
    if (bus.Halted !== 1'b1 || bus.Seq_Err !== 1'b0) begin $display("FAIL halt_flags: got %b%b want 10", bus.Halted, bus.Seq_Err); miscompares++; end vectors++;
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      step();
      if (bus.Cnt !== 3'(k)) begin $display("FAIL timeout_cnt[%0d]: got %0d want %0d", k, bus.Cnt, k); miscompares++; end vectors++;
      if (bus.Seq_Err !== 1'b0) begin $display("FAIL timeout_early_err[%0d]: got %b want 0", k, bus.Seq_Err); miscompares++; end vectors++;
    end
    step();
    if (bus.Seq_Err !== 1'b1) begin $display("FAIL timeout_seqerr: got %b want 1", bus.Seq_Err); miscompares++; end vectors++;
    if (bus.Cnt !== 3'd7) begin $display("FAIL timeout_cnt_held: got %0d want 7", bus.Cnt); miscompares++; end vectors++;
    bus.Buff_PC = 1'b1; bus.PC_next = 16'h0033;
    step(); step();
    bus.Buff_PC = 1'b0;
    if (bus.PC !== 16'h0000 || bus.Cnt !== 3'd7) begin $display("FAIL err_frozen: got pc %h cnt %0d want 0000/7", bus.PC, bus.Cnt); miscompares++; end vectors++;
    if (bus.Seq_Err !== 1'b1 || bus.Halted !== 1'b0) begin $display("FAIL err_flags: got %b%b want 10", bus.Seq_Err, bus.Halted); miscompares++; end vectors++;
    Rst = 1'b1;
    step();
    if (bus.Seq_Err !== 1'b0 || bus.Cnt !== 3'd0) begin $display("FAIL err_reset: got err %b cnt %0d want 0/0", bus.Seq_Err, bus.Cnt); miscompares++; end vectors++;
    Rst = 1'b0;
  endtask

  task automatic test_illegal_buff();
    do_reset();
    bus.Buff_PC = 1'b1; bus.PC_next = 16'h0055;
    step();
    bus.Buff_PC = 1'b0;
    if (bus.Seq_Err !== 1'b1) begin $display("FAIL illegal_seqerr: got %b want 1", bus.Seq_Err); miscompares++; end vectors++;
    if (bus.PC !== 16'h0000 || bus.Retired !== 16'd0) begin $display("FAIL illegal_ignored: got pc %h ret %0d want 0000/0", bus.PC, bus.Retired); miscompares++; end vectors++;
    if (bus.Cnt !== 3'd1 || bus.IR !== 16'h0800) begin $display("FAIL illegal_fetch: got cnt %0d ir %h want 1/0800", bus.Cnt, bus.IR); miscompares++; end vectors++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    step();
    bus.Buff_PC = 1'b1; bus.PC_next = 16'h0020;
    step();
    bus.Buff_PC = 1'b0;
    step(); step(); step(); step();
    if (bus.Cnt !== 3'd4 || bus.PC !== 16'h0020 || bus.Retired !== 16'd1) begin $display("FAIL mid_setup: got cnt %0d pc %h ret %0d want 4/0020/1", bus.Cnt, bus.PC, bus.Retired); miscompares++; end vectors++;
    Rst = 1'b1; bus.Buff_PC = 1'b1; bus.PC_next = 16'h0099;
    step();
    Rst = 1'b0; bus.Buff_PC = 1'b0;
    if (bus.PC !== 16'h0000) begin $display("FAIL mid_pc: got %h want %h", bus.PC, 16'h0000); miscompares++; end vectors++;
    if (bus.Retired !== 16'd0) begin $display("FAIL mid_retired: got %0d want 0", bus.Retired); miscompares++; end vectors++;
    if (bus.Cnt !== 3'd0 || bus.IR !== 16'h0000) begin $display("FAIL mid_cnt_ir: got cnt %0d ir %h want 0/0000", bus.Cnt, bus.IR); miscompares++; end vectors++;
  endtask

  initial begin
    bus.Buff_PC = 1'b0;
    bus.Done    = 1'b0;
    bus.PC_next = 16'h0000;
    test_reset();
    test_normal();
    test_back_to_back();
    test_halt();
    test_timeout();
    test_illegal_buff();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Produces the instruction stream and step count that the instruction decoder consumes.
- Holds the PC and presents it as the instruction-memory address. Latches the fetched word into IR and drives InsM/InsL and the step counter Cnt.
- Restarts the step count and commits the next PC whenever the decoder asserts Buff_PC. Stops on Done.
- Sits between instruction memory / the PC-next mux and the decoder in the multicycle RISC core.

Parameters:
- AW, 16, PC / memory address width
- DW, 16, instruction word width (fixed 16 for this ISA)
- RESET_PC, 16'h0000, PC value loaded on reset
- CNT_MAX, 3'd7, highest legal step value; reaching it without Buff_PC is a sequencing error

Ports:
- clk  in  1  clock, all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- MEM_rdata  in  DW  instruction word read at MEM_addr (combinational read, valid same cycle)
- PC_next  in  AW  next PC from the datapath mux (PC+1 / branch / jump target)
- Buff_PC  in  1  decoder: commit PC_next and end the current instruction
- Done  in  1  decoder: HLT executed
- MEM_addr  out  AW  equals PC
- PC  out  AW  current program counter
- IR  out  DW  latched instruction word
- InsM  out  8  IR[15:8] to decoder
- InsL  out  2  IR[1:0] to decoder
- Cnt  out  3  instruction step counter to decoder
- Halted  out  1  high in HALT state
- Seq_Err  out  1  sticky sequencing error
- Retired  out  16  count of committed instructions (Buff_PC pulses), wraps

Behaviour:
- Reset (Rst=1 at an edge) dominates all other inputs. After the edge:
  - PC=RESET_PC, IR=0, Cnt=0, Halted=0, Seq_Err=0, Retired=0, state RUN.
- Rst held high: state stays as above; no fetch.

Step 0 (fetch):
- At the edge leaving Cnt=0, IR <= MEM_rdata (MEM_addr=PC) and Cnt <= 1.
- The decoder therefore sees the new instruction while Cnt=1.

Steps 1..CNT_MAX, state RUN:
- Buff_PC=1: PC <= PC_next, Cnt <= 0, Retired <= Retired+1. IR is held until the next fetch.
- Buff_PC=0 and Cnt<CNT_MAX: Cnt <= Cnt+1.
- Buff_PC=0 and Cnt==CNT_MAX: Seq_Err <= 1, state ERR, Cnt held.

Buff_PC while Cnt=0:
- Illegal. Ignored for PC and Retired; Seq_Err <= 1. The fetch still proceeds normally.

Done=1 in RUN at Cnt>=1:
- State HALT, Halted=1, Cnt <= 0.
- If Buff_PC is also 1 in the same cycle, the PC/Retired update still occurs (PC points past HLT).
- Done at Cnt=0 is ignored.

HALT and ERR:
- Absorbing until Rst. PC, IR, Cnt, Retired frozen; Buff_PC and Done ignored.
- Seq_Err stays 1 in ERR; Halted=0 in ERR.

Outputs and states:
- InsM/InsL are pure slices of IR, with no extra latency.
- MEM_addr=PC combinationally.
- States: RUN, HALT, ERR; 2-bit encoding.
- Retired wraps 16'hFFFF -> 16'h0000.

Decomposition:
- Shared package (isa_pkg): state encoding constants (S_RUN, S_HALT, S_ERR), CNT_MAX default, RESET_PC default, field positions for InsM/InsL slices.
- One natural sub-module: step_counter (Cnt with clear/enable/saturate-detect). The PC/IR/FSM logic stays in fetch_sequencer.

Test Plan:
1. Reset: Rst=1 for 2 cycles with MEM_rdata=16'h0800 -> PC=0, IR=0, Cnt=0, Halted=0, Seq_Err=0. First edge after release gives IR=16'h0800, InsM=8'h08, Cnt=1.
2. Normal instruction: PC=0, PC_next=16'h0001, Buff_PC pulsed at Cnt=3 -> next edge PC=1, Cnt=0, Retired=1. Following edge latches MEM_rdata at address 1.
3. Back-to-back instructions (Buff_PC at Cnt=1 each time) for 5 instructions, with PC_next=PC+1 and a branch to 16'h0040 on the 3rd -> PC sequence 1, 2, 16'h0040, 16'h0041, 16'h0042; Retired=5; Cnt alternates 0/1.
4. HLT: Done and Buff_PC together at Cnt=2 with PC_next=16'h0010 -> PC=16'h0010, Halted=1, Cnt=0. Further Buff_PC pulses leave PC, Cnt and Retired unchanged.
5. Timeout: no Buff_PC after fetch -> Cnt 1..7, then Seq_Err=1 at the edge seen with Cnt=7, state ERR, Cnt stays 7. Rst clears Seq_Err=0, Cnt=0.
6. Reset mid-instruction: Rst=1 at Cnt=4 with Buff_PC=1 and PC_next=16'h0099 -> PC=RESET_PC (not 16'h0099), Retired=0, Cnt=0.
